// File: rtl/mux_pkg.sv
// Shared constants and width helpers for the arbitrated multiplexer family.
package mux_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  function automatic int sel_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Single-grant arbiter: fixed priority from index 0, or round robin from a
// pointer that moves one past the last winner on every accepted transfer.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int ARB   = ARB_RR,
  parameter int SEL_W = sel_width(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] grant_idx
);

  logic [SEL_W-1:0] ptr;

  // Scan N slots starting at the pointer; wrap by subtraction so non-power-of-two N works.
  always_comb begin : grant_search
    int   start;
    int   idx;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    start     = (ARB == ARB_RR) ? int'(ptr) : 0;
    for (int k = 0; k < N; k++) begin
      idx = start + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found          = 1'b1;
        grant[idx]     = 1'b1;
        grant_idx      = idx[SEL_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if ((ARB == ARB_RR) && advance) begin
      ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + SEL_W'(1);
    end
  end

endmodule

// File: rtl/arb_mux.sv
// N-channel arbitrated mux with valid/ready handshakes and a single-entry
// registered output stage that accepts a new word on the same edge it pops.
module arb_mux
  import mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int ARB   = ARB_RR,
  parameter int SEL_W = sel_width(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   out_sel
);

  logic [N-1:0]     grant;
  logic [SEL_W-1:0] grant_idx;
  logic             can_load;
  logic             xfer;

  assign can_load = !out_valid || out_ready;
  assign in_ready = grant & {N{can_load}};
  assign xfer     = (|in_valid) && can_load;

  rr_arbiter #(
    .N     (N),
    .ARB   (ARB),
    .SEL_W (SEL_W)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (in_valid),
    .advance   (xfer),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Data and index hold on a drain so the last delivered word stays visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[int'(grant_idx)*WIDTH +: WIDTH];
      out_sel   <= grant_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux: four builds (RR N=4, fixed N=4, RR N=3, N=1) checked
// every cycle against a transaction-level model of grant, output and pointer.
module tb_arb_mux;

  localparam int ND = 4;
  int NN[ND] = '{4, 4, 3, 1};
  int AR[ND] = '{1, 0, 1, 1};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ored;
  logic [3:0]   iv[ND];
  logic [127:0] idata[ND];

  logic [3:0]   ir[ND];
  logic [31:0]  odata[ND];
  logic         ovalid[ND];
  logic [1:0]   osel[ND];

  logic [3:0]  ir0, ir1;
  logic [2:0]  ir2;
  logic [0:0]  ir3;
  logic [31:0] od0, od1, od2, od3;
  logic        ov0, ov1, ov2, ov3;
  logic [1:0]  sl0, sl1, sl2;
  logic [0:0]  sl3;

  bit          m_valid[ND];
  logic [31:0] m_data[ND];
  int          m_sel[ND];
  int          m_ptr[ND];
  bit          auto_prod;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  arb_mux #(.WIDTH(32), .N(4), .ARB(1)) u_rr4 (
    .clk(clk), .rst_n(rst_n), .in_data(idata[0]), .in_valid(iv[0]), .in_ready(ir0),
    .out_data(od0), .out_valid(ov0), .out_ready(ored), .out_sel(sl0));
  arb_mux #(.WIDTH(32), .N(4), .ARB(0)) u_fp4 (
    .clk(clk), .rst_n(rst_n), .in_data(idata[1]), .in_valid(iv[1]), .in_ready(ir1),
    .out_data(od1), .out_valid(ov1), .out_ready(ored), .out_sel(sl1));
  arb_mux #(.WIDTH(32), .N(3), .ARB(1)) u_rr3 (
    .clk(clk), .rst_n(rst_n), .in_data(idata[2][95:0]), .in_valid(iv[2][2:0]), .in_ready(ir2),
    .out_data(od2), .out_valid(ov2), .out_ready(ored), .out_sel(sl2));
  arb_mux #(.WIDTH(32), .N(1), .ARB(1)) u_n1 (
    .clk(clk), .rst_n(rst_n), .in_data(idata[3][31:0]), .in_valid(iv[3][0:0]), .in_ready(ir3),
    .out_data(od3), .out_valid(ov3), .out_ready(ored), .out_sel(sl3));

  always_comb begin
    ir[0] = ir0;            ir[1] = ir1;
    ir[2] = {1'b0, ir2};    ir[3] = {3'b000, ir3};
    odata[0] = od0; odata[1] = od1; odata[2] = od2; odata[3] = od3;
    ovalid[0] = ov0; ovalid[1] = ov1; ovalid[2] = ov2; ovalid[3] = ov3;
    osel[0] = sl0; osel[1] = sl1; osel[2] = sl2; osel[3] = {1'b0, sl3};
  end

  // First requesting channel in search order, or -1 when nobody asks.
  function automatic int winner(int d);
    int start;
    start = (AR[d] == 1) ? m_ptr[d] : 0;
    for (int k = 0; k < NN[d]; k++) begin
      int i;
      i = (start + k) % NN[d];
      if (iv[d][i]) return i;
    end
    return -1;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      m_valid[d] = 1'b0;
      m_data[d]  = '0;
      m_sel[d]   = 0;
      m_ptr[d]   = 0;
    end
  endtask

  // Called at a falling edge with inputs already applied; returns at the next falling edge.
  task automatic tick();
    int   w[ND];
    bit   cl;
    bit   acc[ND];
    logic [3:0] er;
    #1;
    for (int d = 0; d < ND; d++) begin
      w[d] = winner(d);
      cl   = !m_valid[d] || ored;
      er   = (w[d] >= 0 && cl) ? 4'(1 << w[d]) : 4'b0000;
      check($sformatf("in_ready d%0d", d),  32'(ir[d]),     32'(er));
      check($sformatf("out_valid d%0d", d), 32'(ovalid[d]), 32'(m_valid[d]));
      check($sformatf("out_data d%0d", d),  odata[d],       m_data[d]);
      check($sformatf("out_sel d%0d", d),   32'(osel[d]),   32'(m_sel[d]));
    end
    @(posedge clk);
    for (int d = 0; d < ND; d++) begin
      cl     = !m_valid[d] || ored;
      acc[d] = (w[d] >= 0) && cl;
      if (acc[d]) begin
        m_valid[d] = 1'b1;
        m_data[d]  = idata[d][w[d]*32 +: 32];
        m_sel[d]   = w[d];
        if (AR[d] == 1) m_ptr[d] = (w[d] + 1) % NN[d];
      end else if (cl) begin
        m_valid[d] = 1'b0;
      end
    end
    @(negedge clk);
    if (auto_prod) begin
      ored = ($urandom % 4) != 0;
      for (int d = 0; d < ND; d++) begin
        for (int i = 0; i < NN[d]; i++) begin
          if ((acc[d] && w[d] == i) || (!iv[d][i] && ($urandom % 3) == 0)) begin
            iv[d][i] = ($urandom % 4) != 0;
            idata[d][i*32 +: 32] = $urandom;
          end
        end
      end
    end
  endtask

  task automatic set_all(logic [3:0] v);
    for (int d = 0; d < ND; d++) begin
      iv[d]    = v;
      idata[d] = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    ored      = 1'b1;
    auto_prod = 1'b0;
    for (int d = 0; d < ND; d++) begin
      iv[d]    = '0;
      idata[d] = '0;
    end
    model_reset();

    @(negedge clk);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // Single stream on channel 2 of the round-robin N=4 build.
    for (int k = 0; k < 6; k++) begin
      iv[0] = 4'b0100;
      idata[0][64 +: 32] = 32'hA5A5_0001 + 32'(k);
      tick();
    end
    iv[0] = '0;
    tick();

    // Every channel requesting continuously.
    for (int k = 0; k < 12; k++) begin
      set_all(4'hF);
      tick();
    end

    // Fixed-priority contention, then the low channel drops out.
    for (int k = 0; k < 6; k++) begin
      set_all(4'b1010);
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      set_all(4'b1000);
      tick();
    end

    // Backpressure: sink stalls for five cycles, then releases.
    set_all(4'hF);
    ored = 1'b0;
    repeat (5) tick();
    ored = 1'b1;
    repeat (3) tick();

    // Randomised producers and sink.
    auto_prod = 1'b1;
    repeat (400) tick();
    auto_prod = 1'b0;

    // Reset in the middle of a stall.
    set_all(4'hF);
    ored = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      check($sformatf("rst out_valid d%0d", d), 32'(ovalid[d]), 32'd0);
      check($sformatf("rst out_data d%0d", d),  odata[d],       32'd0);
      check($sformatf("rst out_sel d%0d", d),   32'(osel[d]),   32'd0);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    ored  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      set_all(4'hF);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
